// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one SRAM-like memory bus between the IF requester and the data requester.
// Latency: 0 cycles on both paths (requests to mem_*, mem_data_ok/rdata to requesters).
// Backpressure: mem_addr_ok stalls the winner; the grant stays locked until accepted; no issue while DEPTH are outstanding.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   inst_* / data_*               requester channels (req, wr, size, wstrb, addr, wdata in;
//                                 addr_ok, data_ok, rdata out)
//   mem_*                         downstream request (out) and mem_addr_ok/mem_data_ok/mem_rdata (in)
//   outstanding                   number of accepted-but-unanswered transactions
//   spurious_ok                   sticky: mem_data_ok seen with nothing outstanding
module mem_bus_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic [3:0]  outstanding,
  output logic        spurious_ok
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_INST = 2'd1,
    HOLD_DATA = 2'd2
  } state_t;

  state_t           state;
  logic [DEPTH-1:0] id_fifo;   // 0 = INST, 1 = DATA
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic full;
  logic empty;
  logic sel_data;
  logic push;
  logic pop;
  logic head_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (outstanding == 4'(DEPTH));
    empty    = (outstanding == 4'd0);
    sel_data = 1'b0;
    mem_req  = 1'b0;
    case (state)
      IDLE: begin
        // When nothing can issue the bus idles on the INST fields.
        sel_data = data_req & ~full;
        mem_req  = (data_req | inst_req) & ~full;
      end
      HOLD_INST: begin
        sel_data = 1'b0;
        mem_req  = inst_req;
      end
      HOLD_DATA: begin
        sel_data = 1'b1;
        mem_req  = data_req;
      end
      default: begin
        sel_data = 1'b0;
        mem_req  = 1'b0;
      end
    endcase

    push         = mem_req & mem_addr_ok;
    inst_addr_ok = push & ~sel_data;
    data_addr_ok = push & sel_data;

    head_id      = id_fifo[rd_ptr];
    pop          = mem_data_ok & ~empty;
    inst_data_ok = pop & ~head_id;
    data_data_ok = pop & head_id;
  end

  assign mem_wr     = sel_data ? data_wr    : inst_wr;
  assign mem_size   = sel_data ? data_size  : inst_size;
  assign mem_wstrb  = sel_data ? data_wstrb : inst_wstrb;
  assign mem_addr   = sel_data ? data_addr  : inst_addr;
  assign mem_wdata  = sel_data ? data_wdata : inst_wdata;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      id_fifo     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= 4'd0;
      spurious_ok <= 1'b0;
    end else begin
      case (state)
        IDLE:      if (mem_req && !mem_addr_ok) state <= sel_data ? HOLD_DATA : HOLD_INST;
        // Leaving HOLD on a dropped request recovers from a requester protocol violation.
        HOLD_INST: if (!inst_req || mem_addr_ok) state <= IDLE;
        HOLD_DATA: if (!data_req || mem_addr_ok) state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (push) begin
        id_fifo[wr_ptr] <= sel_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

      if (mem_data_ok && empty) spurious_ok <= 1'b1;
    end
  end

endmodule
